// File: rtl/logic_unit_stage.sv
// rtl/logic_unit_stage.sv - registered 8-bit bitwise logic stage with skid buffer and valid/ready handoff
// Optional build macro LOGIC_UNIT_SHIFT_EN: ops 110/111 become SHL/SHR A by 1 with carry.
module logic_unit_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic             carry,
  output logic [CNT_W-1:0] done_cnt
);

  logic [WIDTH-1:0] w_res_y;
  logic             w_res_c;
  logic             w_res_z;
  logic             w_res_p;
  logic             w_acc;
  logic             w_drain;

  logic             r_or_valid;
  logic [WIDTH-1:0] r_or_y;
  logic             r_or_z;
  logic             r_or_p;
  logic             r_or_c;
  logic             r_sk_valid;
  logic [WIDTH-1:0] r_sk_y;
  logic             r_sk_z;
  logic             r_sk_p;
  logic             r_sk_c;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_done_cnt;

  always_comb begin
    w_res_y = '0;
    w_res_c = 1'b0;
    case (op)
      3'b000: w_res_y = a & b;
      3'b001: w_res_y = a | b;
      3'b010: w_res_y = a ^ b;
      3'b011: w_res_y = ~(a & b);
      3'b100: w_res_y = ~(a | b);
      3'b101: w_res_y = ~(a ^ b);
`ifdef LOGIC_UNIT_SHIFT_EN
      3'b110: begin
        w_res_y = {a[WIDTH-2:0], 1'b0};
        w_res_c = a[WIDTH-1];
      end
      3'b111: begin
        w_res_y = {1'b0, a[WIDTH-1:1]};
        w_res_c = a[0];
      end
`else
      3'b110: w_res_y = ~a;
      3'b111: w_res_y = b;
`endif
      default: w_res_y = '0;
    endcase
  end

  assign w_res_z = (w_res_y == '0);
  assign w_res_p = ^w_res_y;
  assign w_acc   = in_valid && r_in_ready;
  assign w_drain = r_or_valid && out_ready;

  // SK is only ever filled while OR is full, so OR refills from SK first;
  // in_ready is low whenever SK is full, so no accept competes with that move.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_or_valid <= 1'b0;
      r_or_y     <= '0;
      r_or_z     <= 1'b0;
      r_or_p     <= 1'b0;
      r_or_c     <= 1'b0;
      r_sk_valid <= 1'b0;
      r_sk_y     <= '0;
      r_sk_z     <= 1'b0;
      r_sk_p     <= 1'b0;
      r_sk_c     <= 1'b0;
      r_in_ready <= 1'b1;
      r_done_cnt <= '0;
    end else begin
      if (w_drain) begin
        r_done_cnt <= r_done_cnt + CNT_W'(1);
      end
      if (!r_or_valid || w_drain) begin
        if (r_sk_valid) begin
          r_or_valid <= 1'b1;
          r_or_y     <= r_sk_y;
          r_or_z     <= r_sk_z;
          r_or_p     <= r_sk_p;
          r_or_c     <= r_sk_c;
          r_sk_valid <= 1'b0;
          r_in_ready <= 1'b1;
        end else if (w_acc) begin
          r_or_valid <= 1'b1;
          r_or_y     <= w_res_y;
          r_or_z     <= w_res_z;
          r_or_p     <= w_res_p;
          r_or_c     <= w_res_c;
        end else begin
          r_or_valid <= 1'b0;
        end
      end else if (w_acc) begin
        r_sk_valid <= 1'b1;
        r_sk_y     <= w_res_y;
        r_sk_z     <= w_res_z;
        r_sk_p     <= w_res_p;
        r_sk_c     <= w_res_c;
        r_in_ready <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_or_valid;
  assign y         = r_or_y;
  assign zero      = r_or_z;
  assign parity    = r_or_p;
  assign carry     = r_or_c;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_logic_unit_stage.sv
// tb/tb_logic_unit_stage.sv - randomized self-checking bench for logic_unit_stage against a queue model
module tb_logic_unit_stage;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic          zero;
  logic          parity;
  logic          carry;
  logic [CW-1:0] done_cnt;

  int errors = 0;
  int checks = 0;

  // Model: results in flight, oldest first, each {carry, y}; at most two (OR + SK)
  logic [W:0] q[$];
  int         m_cnt;
  logic [W-1:0] held_y;

  logic [W-1:0] sweep_y [6];

  logic_unit_stage #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .parity(parity), .carry(carry), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    logic [W-1:0] r;
    logic         c;
    c = 1'b0;
    case (o)
      3'd0: r = x & z;
      3'd1: r = x | z;
      3'd2: r = x ^ z;
      3'd3: r = ~(x & z);
      3'd4: r = ~(x | z);
      3'd5: r = ~(x ^ z);
`ifdef LOGIC_UNIT_SHIFT_EN
      3'd6: begin r = W'(x * 2); c = x[W-1]; end
      3'd7: begin r = x / 2;     c = x[0];   end
`else
      3'd6: r = ~x;
      3'd7: r = z;
`endif
      default: r = '0;
    endcase
    return {c, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("done_cnt", 32'(done_cnt), 32'(m_cnt % (1 << CW)));
    if (q.size() > 0) begin
      check("y", 32'(y), 32'(q[0][W-1:0]));
      check("zero", 32'(zero), 32'(q[0][W-1:0] == 0));
      check("parity", 32'(parity), 32'($countones(q[0][W-1:0]) % 2));
      check("carry", 32'(carry), 32'(q[0][W]));
    end
  endtask

  // Called just after a negedge: check current outputs, drive, advance one clock
  task automatic step(input logic r, input logic iv, input logic [2:0] o,
                      input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ordy);
    bit acc, xfer;
    check_state();
    rst = r; in_valid = iv; op = o; a = aa; b = bb; out_ready = ordy;
    acc  = iv && (q.size() < 2);
    xfer = ordy && (q.size() > 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (xfer) begin
        void'(q.pop_front());
        m_cnt++;
      end
      if (acc) q.push_back(ref_op(o, aa, bb));
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    sweep_y = '{8'h0A, 8'hAF, 8'hA5, 8'hF5, 8'h50, 8'h5A};
    m_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_y", 32'(y), 0);
    check("rst_flags", {29'd0, zero, parity, carry}, 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_done_cnt", 32'(done_cnt), 0);

    step(0, 1, 3'd0, 8'hF0, 8'h3C, 1);
    check("first_y", 32'(y), 32'h30);
    check("first_valid", 32'(out_valid), 1);
    check("first_zero_par", {30'd0, zero, parity}, 0);
    step(0, 0, 3'd0, 8'h00, 8'h00, 1);
    check("first_done", 32'(done_cnt), 1);

    for (int i = 0; i < 6; i++) begin
      step(0, 1, 3'(i), 8'hAA, 8'h0F, 1);
      check("sweep_y", 32'(y), 32'(sweep_y[i]));
      check("sweep_in_ready", 32'(in_ready), 1);
    end
    step(0, 1, 3'd0, 8'h55, 8'hAA, 1);
    check("zero_y", 32'(y), 0);
    check("zero_flags", {30'd0, zero, parity}, 32'b10);
`ifdef LOGIC_UNIT_SHIFT_EN
    step(0, 1, 3'd6, 8'h81, 8'h00, 1);
    check("shl_y", 32'(y), 32'h02);
    check("shl_carry", 32'(carry), 1);
    step(0, 1, 3'd7, 8'h81, 8'h00, 1);
    check("shr_y", 32'(y), 32'h40);
    check("shr_carry", 32'(carry), 1);
`else
    step(0, 1, 3'd6, 8'h01, 8'h77, 1);
    check("not_y", 32'(y), 32'hFE);
    check("not_flags", {30'd0, parity, carry}, 32'b10);
`endif
    step(0, 0, 3'd0, 8'h00, 8'h00, 1);

    // Stall: OR, SK, then a refused third input
    step(0, 1, 3'd1, 8'h12, 8'h40, 0);
    held_y = y;
    step(0, 1, 3'd2, 8'h33, 8'h0F, 0);
    check("stall_in_ready", 32'(in_ready), 0);
    step(0, 1, 3'd3, 8'hFF, 8'hFF, 0);
    check("stall_y_held", 32'(y), 32'(held_y));
    check("stall_y_val", 32'(y), 32'h52);
    for (int i = 0; i < 4; i++) step(0, 0, 3'd0, 8'h00, 8'h00, 1);
    check("stall_drained", 32'(out_valid), 0);

    // Reset with OR and SK both full
    step(0, 1, 3'd0, 8'hFF, 8'h81, 0);
    step(0, 1, 3'd1, 8'h01, 8'h02, 0);
    check("pre_rst_sk_full", 32'(in_ready), 0);
    step(1, 0, 3'd0, 8'h00, 8'h00, 1);
    check("post_rst_valid", 32'(out_valid), 0);
    check("post_rst_ready", 32'(in_ready), 1);
    check("post_rst_cnt", 32'(done_cnt), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 3'd0, 8'h00, 8'h00, 1);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), 3'($urandom),
           W'($urandom), W'($urandom), ($urandom_range(0, 9) < 6));
    end
    check_state();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
